// File: rtl/ttl_univ_shift_reg.sv
// Universal shift register (74LS194 style, WIDTH bits) with a saturating shift counter.
// Define TTL_OUT_DELAY_EN to drive q/so_r/so_l/reload_req through rise/fall delays.
module ttl_univ_shift_reg #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
  parameter int              DELAY_RISE = 14,
  parameter int              DELAY_FALL = 10,
  localparam int             CNT_W      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             set,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             reload_req
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  if (WIDTH < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
    $error("ttl_univ_shift_reg: WIDTH must be >= 2 and delays non-negative");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reload;

  // Counter saturates at WIDTH so an exhausted shifter stays flagged until reloaded.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (reset) begin
      q_d   = '0;
      cnt_d = CNT_MAX;
    end else if (ce) begin
      if (set) begin
        q_d   = SET_VALUE;
        cnt_d = '0;
      end else begin
        case (mode)
          MODE_SHR: begin
            q_d = {sr_in, q_q[WIDTH-1:1]};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          MODE_SHL: begin
            q_d = {q_q[WIDTH-2:0], sl_in};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          MODE_LOAD: begin
            q_d   = d;
            cnt_d = '0;
          end
          MODE_HOLD: ;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    q_q   <= q_d;
    cnt_q <= cnt_d;
  end

  assign reload    = (cnt_q == CNT_MAX);
  assign shift_cnt = cnt_q;

`ifdef TTL_OUT_DELAY_EN
  assign #(DELAY_RISE, DELAY_FALL) q          = q_q;
  assign #(DELAY_RISE, DELAY_FALL) so_r       = q_q[0];
  assign #(DELAY_RISE, DELAY_FALL) so_l       = q_q[WIDTH-1];
  assign #(DELAY_RISE, DELAY_FALL) reload_req = reload;
`else
  assign q          = q_q;
  assign so_r       = q_q[0];
  assign so_l       = q_q[WIDTH-1];
  assign reload_req = reload;
`endif

endmodule

// File: tb/tb_ttl_univ_shift_reg.sv
// Scoreboard bench for ttl_univ_shift_reg: directed vectors on an 8-bit and a 12-bit instance.
module tb_ttl_univ_shift_reg;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    int          cnt;
    bit          rl;
    string       tag;
  } exp_t;

  exp_t sb8[$];
  exp_t sb12[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // 8-bit instance
  logic       reset8, ce8, set8, sri8, sli8;
  logic [1:0] mode8;
  logic [7:0] d8, q8;
  logic       sor8, sol8, rl8;
  logic [3:0] cnt8;

  // 12-bit instance
  logic        reset12, ce12, set12, sri12, sli12;
  logic [1:0]  mode12;
  logic [11:0] d12, q12;
  logic        sor12, sol12, rl12;
  logic [3:0]  cnt12;

  ttl_univ_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .ce(ce8), .set(set8), .mode(mode8), .d(d8),
    .sr_in(sri8), .sl_in(sli8), .q(q8), .so_r(sor8), .so_l(sol8),
    .shift_cnt(cnt8), .reload_req(rl8)
  );

  ttl_univ_shift_reg #(.WIDTH(12)) dut12 (
    .clk(clk), .reset(reset12), .ce(ce12), .set(set12), .mode(mode12), .d(d12),
    .sr_in(sri12), .sl_in(sli12), .q(q12), .so_r(sor12), .so_l(sol12),
    .shift_cnt(cnt12), .reload_req(rl12)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitors sample 15 ns after the edge, past the rise delay of the delayed build.
  always @(posedge clk) begin
    exp_t e;
    #15;
    if (sb8.size() > 0) begin
      e = sb8.pop_front();
      chk({e.tag, ".q"},     16'(q8),   e.q);
      chk({e.tag, ".cnt"},   16'(cnt8), 16'(e.cnt));
      chk({e.tag, ".rl"},    16'(rl8),  16'(e.rl));
      chk({e.tag, ".so_r"},  16'(sor8), 16'(e.q[0]));
      chk({e.tag, ".so_l"},  16'(sol8), 16'(e.q[7]));
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #15;
    if (sb12.size() > 0) begin
      e = sb12.pop_front();
      chk({e.tag, ".q"},    16'(q12),   e.q);
      chk({e.tag, ".cnt"},  16'(cnt12), 16'(e.cnt));
      chk({e.tag, ".rl"},   16'(rl12),  16'(e.rl));
      chk({e.tag, ".so_r"}, 16'(sor12), 16'(e.q[0]));
      chk({e.tag, ".so_l"}, 16'(sol12), 16'(e.q[11]));
    end
  end

  task automatic step8(input logic r, input logic c, input logic s, input logic [1:0] m,
                       input logic [7:0] dv, input logic sr, input logic sl,
                       input logic [7:0] eq, input int ec, input bit erl, input string tag);
    exp_t e;
    reset8 = r; ce8 = c; set8 = s; mode8 = m; d8 = dv; sri8 = sr; sli8 = sl;
    @(posedge clk);
    e.q = 16'(eq); e.cnt = ec; e.rl = erl; e.tag = tag;
    sb8.push_back(e);
    #17;
  endtask

  task automatic step12(input logic r, input logic c, input logic s, input logic [1:0] m,
                        input logic [11:0] dv, input logic sr,
                        input logic [11:0] eq, input int ec, input bit erl, input string tag);
    exp_t e;
    reset12 = r; ce12 = c; set12 = s; mode12 = m; d12 = dv; sri12 = sr; sli12 = 1'b0;
    @(posedge clk);
    e.q = 16'(eq); e.cnt = ec; e.rl = erl; e.tag = tag;
    sb12.push_back(e);
    #17;
  endtask

  // Right-shift trace of 12'hA5C with sr_in=1
  logic [11:0] shr12 [20] = '{12'hD2E, 12'hE97, 12'hF4B, 12'hFA5, 12'hFD2, 12'hFE9, 12'hFF4,
                              12'hFFA, 12'hFFD, 12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                              12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
  logic [7:0]  shr8  [8]  = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};

  initial begin
    reset8 = 1; ce8 = 0; set8 = 0; mode8 = 0; d8 = 0; sri8 = 0; sli8 = 0;
    reset12 = 1; ce12 = 0; set12 = 0; mode12 = 0; d12 = 0; sri12 = 0; sli12 = 0;

    // Reset with random inputs (including ce=0) on both instances
    for (int i = 0; i < 2; i++) begin
      reset12 = 1'b1; ce12 = 1'(i); set12 = 1'($urandom); mode12 = 2'($urandom); d12 = 12'($urandom);
      step8(1'b1, 1'(i), 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            8'h00, 8, 1'b1, "rst8");
      sb12.push_back('{q: 16'h0, cnt: 12, rl: 1'b1, tag: "rst12"});
    end
    reset12 = 1'b0; ce12 = 1'b0;

    // Load A5 then 8 right shifts, then one extra shift to probe saturation
    step8(0, 1, 0, 2'b11, 8'hA5, 0, 0, 8'hA5, 0, 0, "ld_a5");
    for (int i = 0; i < 8; i++)
      step8(0, 1, 0, 2'b01, 8'h00, 0, 0, shr8[i], i + 1, (i == 7), $sformatf("shr%0d", i + 1));
    step8(0, 1, 0, 2'b01, 8'h00, 1, 0, 8'h80, 8, 1, "shr_sat");

    // Shift left with fill from a load of 01
    step8(0, 1, 0, 2'b11, 8'h01, 0, 0, 8'h01, 0, 0, "ld_01");
    step8(0, 1, 0, 2'b10, 8'h00, 0, 1, 8'h03, 1, 0, "shl1");
    step8(0, 1, 0, 2'b10, 8'h00, 0, 1, 8'h07, 2, 0, "shl2");
    step8(0, 1, 0, 2'b10, 8'h00, 0, 1, 8'h0F, 3, 0, "shl3");

    // Priority: reset beats set and load; set beats load
    step8(1, 1, 1, 2'b11, 8'h3C, 0, 0, 8'h00, 8, 1, "prio_rst");
    step8(0, 1, 1, 2'b11, 8'h3C, 0, 0, 8'hFF, 0, 0, "prio_set");

    // Clock enable low blocks shift and set
    step8(0, 1, 0, 2'b11, 8'h5A, 0, 0, 8'h5A, 0, 0, "ld_5a");
    for (int i = 0; i < 5; i++)
      step8(0, 0, 1, 2'b01, 8'hFF, 1, 1, 8'h5A, 0, 0, $sformatf("ce0_%0d", i));
    step8(0, 1, 0, 2'b00, 8'hFF, 1, 1, 8'h5A, 0, 0, "hold");

    // Reset in the middle of shifting
    step8(0, 1, 0, 2'b01, 8'h00, 1, 0, 8'hAD, 1, 0, "shr_mid");
    step8(1, 1, 0, 2'b01, 8'h00, 1, 0, 8'h00, 8, 1, "rst_mid");
    ce8 = 1'b0; reset8 = 1'b0;

    // WIDTH=12: load then 20 right shifts; counter pins at 12
    step12(0, 1, 0, 2'b11, 12'hA5C, 1, 12'hA5C, 0, 0, "w12_ld");
    for (int i = 0; i < 20; i++)
      step12(0, 1, 0, 2'b01, 12'h000, 1, shr12[i], (i + 1 > 12) ? 12 : i + 1, (i >= 11),
             $sformatf("w12_shr%0d", i + 1));
    ce12 = 1'b0;

    // Drain the scoreboards with a bounded wait
    for (int i = 0; i < 10 && (sb8.size() > 0 || sb12.size() > 0); i++) @(negedge clk);
    if (sb8.size() > 0 || sb12.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb8.size() + sb12.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
